// File: rtl/rcv_pkg.sv
// Shared definitions for the rcv_sched request scheduler.
//   state_t  : scheduler FSM states
//   NREQ_DEF : default number of requesters
//   TMO_DEF  : default WAIT-state timeout in cycles
//   ID_W     : width of a requester index
//   next_ptr : round-robin successor of a requester index
package rcv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int NREQ_DEF = 3;
    localparam int TMO_DEF  = 16;
    localparam int ID_W     = 2;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] idx, input int nreq);
        if (int'(idx) >= nreq - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rcv_sched_if.sv
// Bundle of all non-clock signals around rcv_sched.
//   requester side : req, req_data, req_last (in), gnt (out)
//   response side  : rsp_valid, rsp_id, rsp_data, rsp_err (out)
//   rcv_c side     : rcv_c_in1/2/3 (out), rcv_c_out1/2 (in)
// master = the scheduler, slave = its environment (requesters and rcv_c).
interface rcv_sched_if #(
    parameter int NREQ = rcv_pkg::NREQ_DEF
);
    import rcv_pkg::*;

    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   gnt;

    logic              rsp_valid;
    logic [ID_W-1:0]   rsp_id;
    logic [7:0]        rsp_data;
    logic              rsp_err;

    logic              rcv_c_in1;
    logic [7:0]        rcv_c_in2;
    logic              rcv_c_in3;
    logic [7:0]        rcv_c_out1;
    logic              rcv_c_out2;

    modport master (
        input  req, req_data, req_last, rcv_c_out1, rcv_c_out2,
        output gnt, rsp_valid, rsp_id, rsp_data, rsp_err,
               rcv_c_in1, rcv_c_in2, rcv_c_in3
    );

    modport slave (
        output req, req_data, req_last, rcv_c_out1, rcv_c_out2,
        input  gnt, rsp_valid, rsp_id, rsp_data, rsp_err,
               rcv_c_in1, rcv_c_in2, rcv_c_in3
    );

endinterface

// File: rtl/rcv_rr_arb.sv
// Combinational round-robin picker.
//   req     : pending requests
//   ptr     : index where the search starts
//   lock    : burst lock active
//   owner   : requester holding the lock
//   win     : one-hot winner
//   win_idx : index of the winner
//   win_any : a winner exists
module rcv_rr_arb
    import rcv_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            lock,
    input  logic [ID_W-1:0] owner,
    output logic [NREQ-1:0] win,
    output logic [ID_W-1:0] win_idx,
    output logic            win_any
);

    logic [ID_W:0] sum;

    always_comb begin
        sum     = '0;
        win_idx = '0;
        win_any = 1'b0;
        win     = '0;
        if (lock && req[owner]) begin
            // A burst in progress keeps the scheduler while its owner still requests.
            win_idx = owner;
            win_any = 1'b1;
        end else begin
            // Walk ptr, ptr+1, ... (mod NREQ); the first pending request wins.
            for (int j = 0; j < NREQ; j++) begin
                sum = {1'b0, ptr} + (ID_W+1)'(j);
                if (sum >= (ID_W+1)'(NREQ)) begin
                    sum = sum - (ID_W+1)'(NREQ);
                end
                if (!win_any && req[sum[ID_W-1:0]]) begin
                    win_idx = sum[ID_W-1:0];
                    win_any = 1'b1;
                end
            end
        end
        if (win_any) begin
            win[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rcv_sched.sv
// Round-robin scheduler that forwards one requester byte at a time to the
// rcv_c engine and returns its result (or a timeout) as a response.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : rcv_sched_if.master carrying requester, response and rcv_c signals
// Only one rcv_c transaction is ever outstanding: IDLE -> ISSUE -> WAIT -> RESP.
module rcv_sched
    import rcv_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int TMO  = TMO_DEF
) (
    input  logic        clk,
    input  logic        rst,
    rcv_sched_if.master bus
);

    state_t          state;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] owner;
    logic            lock;
    logic [7:0]      cnt;

    logic [NREQ-1:0] win;
    logic [ID_W-1:0] win_idx;
    logic            win_any;

    rcv_rr_arb #(.NREQ(NREQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .lock    (lock),
        .owner   (owner),
        .win     (win),
        .win_idx (win_idx),
        .win_any (win_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cur_id        <= '0;
            ptr           <= '0;
            owner         <= '0;
            lock          <= 1'b0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.rcv_c_in1 <= 1'b0;
            bus.rcv_c_in2 <= '0;
            bus.rcv_c_in3 <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state below raises them.
            bus.gnt       <= '0;
            bus.rcv_c_in1 <= 1'b0;
            bus.rsp_valid <= 1'b0;

            case (state)
                // IDLE: arbitrate and latch the winner's byte onto the rcv_c operand lines.
                ST_IDLE: begin
                    if (lock && !bus.req[owner]) begin
                        lock <= 1'b0;
                    end
                    if (win_any) begin
                        cur_id        <= win_idx;
                        bus.gnt       <= win;
                        bus.rcv_c_in1 <= 1'b1;
                        bus.rcv_c_in2 <= bus.req_data[{win_idx, 3'b000} +: 8];
                        bus.rcv_c_in3 <= bus.req_last[win_idx];
                        state         <= ST_ISSUE;
                    end
                end

                // ISSUE: grant and start pulse are visible this cycle.
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end

                // WAIT: done wins over a timeout landing in the same cycle.
                ST_WAIT: begin
                    if (bus.rcv_c_out2) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= cur_id;
                        bus.rsp_data  <= bus.rcv_c_out1;
                        bus.rsp_err   <= 1'b0;
                        state         <= ST_RESP;
                    end else if (cnt == 8'(TMO - 1)) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_id    <= cur_id;
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                // RESP: advance the pointer; a non-final byte that completed locks its owner.
                ST_RESP: begin
                    ptr   <= next_ptr(cur_id, NREQ);
                    owner <= cur_id;
                    lock  <= !bus.rcv_c_in3 && !bus.rsp_err;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rcv_sched.sv
module tb_rcv_sched;
    import rcv_pkg::*;

    localparam int NREQ = 3;
    localparam int TMO  = 16;
    localparam int NRND = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rcv_sched_if #(.NREQ(NREQ)) bus();

    rcv_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // rcv_c stand-in: done strobe cur_lat cycles after the start pulse (0 = never)
    int         done_at = -1000;
    int         cur_lat = 0;
    int         rc_lat  = 1;
    logic       rc_rand = 1'b0;
    logic       rc_auto = 1'b0;
    logic [7:0] rc_fixed = 8'h00;
    logic [7:0] rc_byte  = 8'h00;

    // reference model of the arbitration rules
    int   m_ptr   = 0;
    int   m_owner = 0;
    logic m_lock  = 1'b0;

    typedef struct {
        logic [NREQ-1:0]   req;
        logic [8*NREQ-1:0] data;
        logic [NREQ-1:0]   last;
        int                lat;
        logic [7:0]        out1;
        logic [NREQ-1:0]   exp_gnt;
        logic [7:0]        exp_in2;
        int                exp_id;
        logic [7:0]        exp_data;
        logic              exp_err;
        int                exp_dly;
    } vec_t;

    typedef struct {
        int         at;
        int         id;
        logic [7:0] data;
        logic       err;
    } rsp_t;

    vec_t tv[9];
    rsp_t eq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        bus.rcv_c_out2 = (cyc == done_at);
        if (bus.rcv_c_in1) begin
            cur_lat = rc_rand ? int'($urandom_range(1, TMO + 3)) : rc_lat;
            done_at = (cur_lat == 0) ? -1000 : cyc + cur_lat;
            rc_byte = bus.rcv_c_in2;
        end
        bus.rcv_c_out1 = rc_auto ? ~rc_byte : rc_fixed;
    endtask

    task automatic wait_gnt(input string name, output int idx, output int at);
        idx = -1;
        at  = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.gnt != '0) begin
                at = cyc;
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.gnt[i]) idx = i;
                end
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: no grant within 40 cycles", name);
    endtask

    task automatic wait_rsp(input string name, output int id, output logic [7:0] data,
                            output logic err, output int at);
        id   = -1;
        data = 8'h00;
        err  = 1'b0;
        at   = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (bus.rsp_valid) begin
                id   = int'(bus.rsp_id);
                data = bus.rsp_data;
                err  = bus.rsp_err;
                at   = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: no rsp_valid within 40 cycles", name);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " gnt"},       32'(bus.gnt),       32'd0);
        check({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, " rsp_err"},   32'(bus.rsp_err),   32'd0);
        check({tag, " rsp_id"},    32'(bus.rsp_id),    32'd0);
        check({tag, " rsp_data"},  32'(bus.rsp_data),  32'd0);
        check({tag, " in1"},       32'(bus.rcv_c_in1), 32'd0);
        check({tag, " in2"},       32'(bus.rcv_c_in2), 32'd0);
        check({tag, " in3"},       32'(bus.rcv_c_in3), 32'd0);
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
        if (m_lock && r[m_owner]) return m_owner;
        for (int k = 0; k < NREQ; k++) begin
            if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         gi, gat, rid, rat, w, free_at;
        logic [7:0] rdata;
        logic       rerr, exp_g, e_err;
        int         ord[4];
        int         bord[4];
        int         nb1;
        int         rem[NREQ];
        logic [NREQ-1:0]   rp, lp;
        logic [8*NREQ-1:0] dp;
        logic [7:0]        b;

        //            req     data        last    lat out1   gnt     in2    id data   err dly
        tv[0] = '{3'b001, 24'h00005A, 3'b111,  3, 8'hA5, 3'b001, 8'h5A, 0, 8'hA5, 1'b0,  4};
        tv[1] = '{3'b100, 24'h112233, 3'b111,  1, 8'hEE, 3'b100, 8'h11, 2, 8'hEE, 1'b0,  2};
        tv[2] = '{3'b110, 24'h443300, 3'b111,  1, 8'h7E, 3'b010, 8'h33, 1, 8'h7E, 1'b0,  2};
        tv[3] = '{3'b011, 24'h0066C3, 3'b111,  5, 8'h3C, 3'b001, 8'hC3, 0, 8'h3C, 1'b0,  6};
        tv[4] = '{3'b111, 24'h778899, 3'b111, 16, 8'h5B, 3'b010, 8'h88, 1, 8'h5B, 1'b0, 17};
        tv[5] = '{3'b101, 24'hAB00CD, 3'b000,  0, 8'hFF, 3'b100, 8'hAB, 2, 8'h00, 1'b1, 17};
        tv[6] = '{3'b101, 24'h560012, 3'b111,  1, 8'h34, 3'b001, 8'h12, 0, 8'h34, 1'b0,  2};
        tv[7] = '{3'b110, 24'h556600, 3'b111, 17, 8'hC0, 3'b010, 8'h66, 1, 8'h00, 1'b1, 17};
        tv[8] = '{3'b111, 24'h9ABCDE, 3'b111,  2, 8'h21, 3'b100, 8'h9A, 2, 8'h21, 1'b0,  3};
        ord  = '{0, 1, 2, 0};
        bord = '{1, 1, 1, 0};

        rst = 1'b1;
        bus.req        = '0;
        bus.req_data   = '0;
        bus.req_last   = '0;
        bus.rcv_c_out1 = '0;
        bus.rcv_c_out2 = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;

        // table of single transactions; pointer state carries from row to row
        for (int v = 0; v < 9; v++) begin
            bus.req      = tv[v].req;
            bus.req_data = tv[v].data;
            bus.req_last = tv[v].last;
            rc_lat       = tv[v].lat;
            rc_fixed     = tv[v].out1;
            wait_gnt("tbl gnt", gi, gat);
            bus.req = '0;
            check("tbl gnt vec", 32'(bus.gnt), 32'(tv[v].exp_gnt));
            check("tbl in1", 32'(bus.rcv_c_in1), 32'd1);
            check("tbl in2", 32'(bus.rcv_c_in2), 32'(tv[v].exp_in2));
            wait_rsp("tbl rsp", rid, rdata, rerr, rat);
            check("tbl rsp_id", rid, tv[v].exp_id);
            check("tbl rsp_data", 32'(rdata), 32'(tv[v].exp_data));
            check("tbl rsp_err", 32'(rerr), 32'(tv[v].exp_err));
            check("tbl latency", rat - gat, tv[v].exp_dly);
        end

        // fairness: all three held, order 0,1,2,0
        bus.req      = 3'b111;
        bus.req_last = 3'b111;
        rc_lat       = 1;
        rc_fixed     = 8'h0F;
        for (int j = 0; j < 4; j++) begin
            wait_gnt("fair gnt", gi, gat);
            check("fair order", gi, ord[j]);
            wait_rsp("fair rsp", rid, rdata, rerr, rat);
            check("fair rsp_id", rid, gi);
        end
        bus.req = '0;

        // burst: requester 1 sends three bytes under lock, then requester 0
        bus.req      = 3'b011;
        bus.req_last = 3'b001;
        bus.req_data = 24'h001030;
        nb1 = 0;
        for (int j = 0; j < 4; j++) begin
            wait_gnt("burst gnt", gi, gat);
            check("burst order", gi, bord[j]);
            if (gi == 1) begin
                nb1++;
                bus.req_data[15:8] = 8'(8'h10 + nb1);
                if (nb1 == 2) bus.req_last[1] = 1'b1;
                if (nb1 == 3) bus.req[1] = 1'b0;
            end else begin
                bus.req[0] = 1'b0;
            end
            wait_rsp("burst rsp", rid, rdata, rerr, rat);
            check("burst rsp_id", rid, gi);
        end
        bus.req = '0;

        // reset during WAIT abandons the transaction
        bus.req      = 3'b111;
        bus.req_last = 3'b111;
        bus.req_data = 24'hF1F2F3;
        rc_lat       = 0;
        wait_gnt("rstw gnt", gi, gat);
        check("rstw first gnt", gi, 1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_zero("rstw");
        done_at = -1000;
        rc_lat  = 1;
        tick();
        check("rstw held valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("rstw held valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        wait_gnt("rstw post gnt", gi, gat);
        check("rstw post gnt vec", 32'(bus.gnt), 32'd1);
        bus.req = '0;
        wait_rsp("rstw post rsp", rid, rdata, rerr, rat);
        check("rstw post rsp_id", rid, 0);

        // randomized traffic against the reference model
        rst = 1'b1;
        tick();
        tick();
        bus.req      = '0;
        bus.req_last = '0;
        done_at      = -1000;
        rst          = 1'b0;
        free_at      = cyc;
        m_ptr        = 0;
        m_lock       = 1'b0;
        m_owner      = 0;
        rc_rand      = 1'b1;
        rc_auto      = 1'b1;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;

        for (int n = 0; n < NRND; n++) begin
            rp = bus.req;
            dp = bus.req_data;
            lp = bus.req_last;
            tick();

            if (eq.size() != 0 && eq[0].at == cyc) begin
                check("rnd rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("rnd rsp_id", 32'(bus.rsp_id), eq[0].id);
                check("rnd rsp_data", 32'(bus.rsp_data), 32'(eq[0].data));
                check("rnd rsp_err", 32'(bus.rsp_err), 32'(eq[0].err));
                void'(eq.pop_front());
            end else begin
                check("rnd stray rsp_valid", 32'(bus.rsp_valid), 32'd0);
            end

            exp_g = (cyc - 1 >= free_at) && (rp != '0);
            check("rnd gnt present", 32'(bus.gnt != '0), 32'(exp_g));
            if (exp_g && bus.gnt != '0) begin
                w = pick(rp);
                b = dp[8*w +: 8];
                check("rnd gnt vec", 32'(bus.gnt), 32'(1) << w);
                check("rnd in2", 32'(bus.rcv_c_in2), 32'(b));
                e_err = (cur_lat > TMO);
                eq.push_back('{cyc + (e_err ? TMO + 1 : cur_lat + 1), w,
                               e_err ? 8'h00 : ~b, e_err});
                free_at = cyc + (e_err ? TMO + 1 : cur_lat + 1) + 1;
                m_ptr   = (w + 1) % NREQ;
                m_owner = w;
                m_lock  = !lp[w] && !e_err;
            end

            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i]) begin
                    rem[i]--;
                    if (rem[i] <= 0) begin
                        bus.req[i] = 1'b0;
                    end else begin
                        bus.req_data[8*i +: 8] = 8'($urandom);
                        bus.req_last[i] = (rem[i] == 1);
                    end
                end else if (!bus.req[i] && n < NRND - 400 && $urandom_range(0, 3) == 0) begin
                    rem[i] = int'($urandom_range(1, 3));
                    bus.req[i] = 1'b1;
                    bus.req_data[8*i +: 8] = 8'($urandom);
                    bus.req_last[i] = (rem[i] == 1);
                end
            end
        end
        check("rnd drained queue", eq.size(), 0);
        check("rnd requests idle", 32'(bus.req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
